// File: rtl/mod_uart_tx_pkg.sv
// Shared constants for the memory-mapped UART transmitter: register map,
// status bit layout and FSM state encoding.
package mod_uart_tx_pkg;

    localparam logic [31:0] REG_STATUS = 32'h0000_0000;
    localparam logic [31:0] REG_DATA   = 32'h0000_0004;
    localparam int unsigned ADDR_SEL_BIT = 2;

    localparam int unsigned STAT_READY = 0;
    localparam int unsigned STAT_BUSY  = 1;
    localparam int unsigned STAT_OVF   = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

endpackage

// File: rtl/mod_uart_tx_fifo.sv
// Byte FIFO with show-ahead read port; push and pop on the same edge both
// take effect, and a push while full is accepted when paired with a pop.
module mod_uart_tx_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [7:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/mod_uart_tx.sv
// UART transmitter bus responder: register decode, sticky overflow flag and
// the 8N1 serialiser FSM draining the byte FIFO onto txd.
module mod_uart_tx
    import mod_uart_tx_pkg::*;
#(
    parameter int unsigned BAUD_DIV   = 434,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        de,
    input  logic [31:0] daddr,
    input  logic        drw,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        txd
);

    localparam int unsigned CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       idx, idx_n;
    logic [7:0]       shift, shift_n;
    logic             txd_n;
    logic             ovf, ovf_n;
    logic             pop;
    logic             push;
    logic             tc;
    logic             sel_data, sel_status;
    logic             wr_data, wr_status, rd_status;
    logic [7:0]       fifo_dout;
    logic             fifo_full, fifo_empty;
    logic             busy;
    logic             unused_bits;

    assign sel_data   = (daddr[ADDR_SEL_BIT] == REG_DATA[ADDR_SEL_BIT]);
    assign sel_status = (daddr[ADDR_SEL_BIT] == REG_STATUS[ADDR_SEL_BIT]);
    assign wr_data    = de & drw & sel_data;
    assign wr_status  = de & drw & sel_status;
    assign rd_status  = de & ~drw & sel_status;
    assign push       = wr_data & (~fifo_full | pop);
    assign tc         = (cnt == CNT_W'(BAUD_DIV - 1));
    assign busy       = (state != ST_IDLE) | ~fifo_empty;
    assign unused_bits = ^{daddr[31:3], daddr[1:0], din[31:8]};

    mod_uart_tx_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (push),
        .din  (din[7:0]),
        .pop  (pop),
        .dout (fifo_dout),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            idx   <= '0;
            shift <= '0;
            txd   <= 1'b1;
            ovf   <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            shift <= shift_n;
            txd   <= txd_n;
            ovf   <= ovf_n;
        end
    end

    // Next-state logic; txd is derived from the next state so it is registered.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shift_n = shift;
        pop     = 1'b0;
        ovf_n   = ovf;
        txd_n   = 1'b1;

        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_n = fifo_dout;
                    cnt_n   = '0;
                    state_n = ST_START;
                end
            end
            ST_START: begin
                if (tc) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    state_n = ST_DATA;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (tc) begin
                    cnt_n   = '0;
                    shift_n = {1'b0, shift[7:1]};
                    idx_n   = idx + 3'd1;
                    if (idx == 3'd7) state_n = ST_STOP;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (tc) begin
                    cnt_n = '0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_n = fifo_dout;
                        state_n = ST_START;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: state_n = ST_IDLE;
        endcase

        case (state_n)
            ST_START: txd_n = 1'b0;
            ST_DATA:  txd_n = shift_n[0];
            default:  txd_n = 1'b1;
        endcase

        // A dropped byte outranks a clear on the same edge.
        if (wr_status && din[STAT_OVF]) ovf_n = 1'b0;
        if (wr_data && fifo_full && !pop) ovf_n = 1'b1;
    end

    always_comb begin
        dout = '0;
        if (rd_status) begin
            dout[STAT_READY] = ~fifo_full;
            dout[STAT_BUSY]  = busy;
            dout[STAT_OVF]   = ovf;
        end
    end

endmodule

// File: tb/tb_mod_uart_tx.sv
// Self-checking bench for mod_uart_tx: randomized bus traffic compared each
// cycle against a timeline model of frame starts, FIFO occupancy and overflow.
module tb_mod_uart_tx;

    localparam int BAUD  = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * BAUD;

    logic        clk = 1'b0;
    logic        rst;
    logic        de;
    logic        drw;
    logic [31:0] daddr;
    logic [31:0] din;
    logic [31:0] dout;
    logic        txd;

    int total = 0;
    int bad   = 0;

    // Scenario schedule: write edges (ascending) and bytes, plus optional clear edge.
    int         sched_off[$];
    logic [7:0] sched_dat[$];
    int         clr_edge;
    int         nk;

    // Model timeline: accepted bytes with write and pop edges, rejected write edges.
    int         acc_w[$];
    int         acc_pop[$];
    logic [7:0] acc_dat[$];
    int         rej_w[$];
    int         model_len;

    always #5 clk = ~clk;

    mod_uart_tx #(
        .BAUD_DIV  (BAUD),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .de   (de),
        .daddr(daddr),
        .drw  (drw),
        .din  (din),
        .dout (dout),
        .txd  (txd)
    );

    function automatic logic frame_bit(input logic [7:0] d, input int i);
        if (i == 0) return 1'b0;
        if (i >= 9) return 1'b1;
        return d[i-1];
    endfunction

    // A frame starts at max(previous start + FRAME, write edge + 1); a write is
    // accepted when the FIFO has room or a pop happens on the same edge.
    task automatic model_build();
        int last_pop;
        acc_w.delete(); acc_pop.delete(); acc_dat.delete(); rej_w.delete();
        last_pop = -100000;
        foreach (sched_off[k]) begin
            int w;
            int in_fifo;
            bit pop_now;
            w = sched_off[k];
            in_fifo = 0;
            pop_now = 1'b0;
            foreach (acc_pop[j]) begin
                if (acc_pop[j] >= w) in_fifo++;
                if (acc_pop[j] == w) pop_now = 1'b1;
            end
            if (in_fifo < DEPTH || pop_now) begin
                int p;
                p = (last_pop + FRAME > w + 1) ? last_pop + FRAME : w + 1;
                acc_w.push_back(w);
                acc_pop.push_back(p);
                acc_dat.push_back(sched_dat[k]);
                last_pop = p;
            end else begin
                rej_w.push_back(w);
            end
        end
        model_len = last_pop + FRAME + 3;
        if (clr_edge + 3 > model_len) model_len = clr_edge + 3;
        nk = 0;
    endtask

    function automatic logic exp_txd(input int e);
        foreach (acc_pop[j])
            if (e >= acc_pop[j] && e < acc_pop[j] + FRAME)
                return frame_bit(acc_dat[j], (e - acc_pop[j]) / BAUD);
        return 1'b1;
    endfunction

    function automatic logic [31:0] exp_stat(input int e);
        logic [31:0] s;
        int held;
        int r;
        s = '0;
        held = 0;
        r = -1;
        foreach (acc_w[j]) begin
            if (acc_w[j] <= e && e < acc_pop[j] + FRAME) s[1] = 1'b1;
            if (acc_w[j] <= e && acc_pop[j] > e) held++;
        end
        s[0] = (held < DEPTH);
        foreach (rej_w[j]) if (rej_w[j] <= e && rej_w[j] > r) r = rej_w[j];
        s[2] = (r >= 0) && !(clr_edge >= 0 && clr_edge <= e && clr_edge > r);
        return s;
    endfunction

    task automatic drive_idle();
        de = 1'b0; drw = 1'b0; daddr = '0; din = '0;
    endtask

    // Drives the bus for edge e, waits for it, then leaves a STATUS read up.
    task automatic play_cycle(input int e);
        logic [31:0] a;
        logic [31:0] d;
        a = $urandom;
        d = $urandom;
        if (nk < sched_off.size() && sched_off[nk] == e) begin
            a[2] = 1'b1; d[7:0] = sched_dat[nk]; de = 1'b1; drw = 1'b1; nk++;
        end else if (e == clr_edge) begin
            a[2] = 1'b0; d[2] = 1'b1; de = 1'b1; drw = 1'b1;
        end else begin
            a[2] = 1'b0; de = 1'b1; drw = 1'b0;
        end
        daddr = a; din = d;
        @(posedge clk); #1;
        a = $urandom; a[2] = 1'b0;
        daddr = a; de = 1'b1; drw = 1'b0; din = $urandom;
        #1;
    endtask

    task automatic test_reset();
        int glitches;
        logic [31:0] a;
        rst = 1'b1;
        drive_idle();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        a = $urandom; daddr = a; de = 1'b0; drw = a[0]; #1;
        total++;
        if (dout !== 32'h0) begin bad++; $display("FAIL reset_deselect dout=%h want=%h", dout, 32'h0); end
        a[2] = 1'b0; daddr = a; de = 1'b1; drw = 1'b0; #1;
        total++;
        if (dout !== 32'h1) begin bad++; $display("FAIL reset_status dout=%h want=%h", dout, 32'h1); end
        a[2] = 1'b1; daddr = a; #1;
        total++;
        if (dout !== 32'h0) begin bad++; $display("FAIL reset_data_read dout=%h want=%h", dout, 32'h0); end
        drive_idle();
        glitches = 0;
        repeat (100) @(negedge clk) if (txd !== 1'b1) glitches++;
        total++;
        if (glitches != 0) begin bad++; $display("FAIL reset_idle_txd low_cycles=%0d want=0", glitches); end
    endtask

    task automatic test_single();
        for (int r = 0; r < 3; r++) begin
            sched_off = {0};
            sched_dat = {(r == 0) ? 8'hA5 : 8'($urandom)};
            clr_edge = -1;
            model_build();
            for (int e = 0; e < model_len; e++) begin
                play_cycle(e);
                total++;
                if (txd !== exp_txd(e)) begin bad++; $display("FAIL single_txd byte=%h e=%0d got=%b want=%b", sched_dat[0], e, txd, exp_txd(e)); end
                total++;
                if (dout !== exp_stat(e)) begin bad++; $display("FAIL single_status e=%0d got=%h want=%h", e, dout, exp_stat(e)); end
            end
            drive_idle();
        end
    endtask

    task automatic test_back_to_back();
        sched_off = {0, 1};
        sched_dat = {8'h55, 8'h0F};
        clr_edge = -1;
        model_build();
        for (int e = 0; e < model_len; e++) begin
            play_cycle(e);
            total++;
            if (txd !== exp_txd(e)) begin bad++; $display("FAIL b2b_txd e=%0d got=%b want=%b", e, txd, exp_txd(e)); end
            total++;
            if (dout !== exp_stat(e)) begin bad++; $display("FAIL b2b_status e=%0d got=%h want=%h", e, dout, exp_stat(e)); end
        end
        drive_idle();
    endtask

    task automatic test_overflow();
        sched_off = {0, 3, 4, 5, 6, 7};
        sched_dat = {8'h00};
        for (int i = 0; i < 5; i++) sched_dat.push_back(8'($urandom));
        clr_edge = 10;
        model_build();
        for (int e = 0; e < model_len; e++) begin
            play_cycle(e);
            total++;
            if (txd !== exp_txd(e)) begin bad++; $display("FAIL ovf_txd e=%0d got=%b want=%b", e, txd, exp_txd(e)); end
            total++;
            if (dout !== exp_stat(e)) begin bad++; $display("FAIL ovf_status e=%0d got=%h want=%h", e, dout, exp_stat(e)); end
        end
        drive_idle();
    endtask

    task automatic test_push_pop_same_edge();
        // Case 0: push onto a single entry as it pops; case 1: push while full as it pops.
        for (int c = 0; c < 2; c++) begin
            if (c == 0) sched_off = {0, 2, 41};
            else        sched_off = {0, 1, 2, 3, 4, 41};
            sched_dat.delete();
            foreach (sched_off[i]) sched_dat.push_back(8'($urandom));
            clr_edge = -1;
            model_build();
            for (int e = 0; e < model_len; e++) begin
                play_cycle(e);
                total++;
                if (txd !== exp_txd(e)) begin bad++; $display("FAIL same_edge_txd case=%0d e=%0d got=%b want=%b", c, e, txd, exp_txd(e)); end
                total++;
                if (dout !== exp_stat(e)) begin bad++; $display("FAIL same_edge_status case=%0d e=%0d got=%h want=%h", c, e, dout, exp_stat(e)); end
            end
            drive_idle();
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            int t;
            sched_off.delete();
            sched_dat.delete();
            t = 0;
            for (int i = 0; i < 6; i++) begin
                sched_off.push_back(t);
                sched_dat.push_back(8'($urandom));
                t += $urandom_range(1, 50);
            end
            clr_edge = sched_off[5] + 1;
            model_build();
            for (int e = 0; e < model_len; e++) begin
                play_cycle(e);
                total++;
                if (txd !== exp_txd(e)) begin bad++; $display("FAIL rand_txd round=%0d e=%0d got=%b want=%b", r, e, txd, exp_txd(e)); end
                total++;
                if (dout !== exp_stat(e)) begin bad++; $display("FAIL rand_status round=%0d e=%0d got=%h want=%h", r, e, dout, exp_stat(e)); end
            end
            drive_idle();
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] vals [2];
        vals[0] = 8'hFF;
        vals[1] = 8'h00;
        for (int v = 0; v < 2; v++) begin
            logic [31:0] a;
            int glitches;
            a = $urandom; a[2] = 1'b1;
            daddr = a; din = {24'($urandom), vals[v]}; de = 1'b1; drw = 1'b1;
            @(posedge clk); #1;
            drive_idle();
            repeat (10) @(posedge clk);
            #1;
            total++;
            if (txd !== frame_bit(vals[v], 9 / BAUD)) begin bad++; $display("FAIL midframe_pre txd=%b want=%b", txd, frame_bit(vals[v], 9 / BAUD)); end
            rst = 1'b1; #1;
            total++;
            if (txd !== 1'b1) begin bad++; $display("FAIL midframe_async txd=%b want=1", txd); end
            @(posedge clk); #2;
            rst = 1'b0;
            glitches = 0;
            repeat (60) @(negedge clk) if (txd !== 1'b1) glitches++;
            total++;
            if (glitches != 0) begin bad++; $display("FAIL midframe_residual low_cycles=%0d want=0", glitches); end
            a = $urandom; a[2] = 1'b0; daddr = a; de = 1'b1; drw = 1'b0; #1;
            total++;
            if (dout !== 32'h1) begin bad++; $display("FAIL midframe_status dout=%h want=%h", dout, 32'h1); end
            drive_idle();
        end
    endtask

    initial begin
        rst = 1'b1;
        drive_idle();
        clr_edge = -1;
        nk = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_push_pop_same_edge();
        test_random();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
